// File: rtl/spi_pkg.sv
// Shared SPI master definitions: FSM state encoding, timing floors and a small sizing helper.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  // Floors that keep SCK/CS wide enough for a slave double-registering them on its own clock.
  localparam int MIN_DIV = 4;
  localparam int MIN_CS  = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: toggles sck every CLK_DIV enabled cycles; rise/fall strobe in the cycle whose edge updates sck.
// Counter restarts from 0 whenever en drops, so each enable window begins with a full half-period.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int DIV = (CLK_DIV < MIN_DIV) ? MIN_DIV : CLK_DIV;
  localparam int CW  = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = en && (cnt == CW'(DIV - 1));
  assign rise = tick && !sck;
  assign fall = tick && sck;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sck <= 1'b0;
    end else begin
      if (!en || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (tick) begin
        sck <= ~sck;
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one full-duplex DATA_WIDTH-bit frame per accepted start; every output is registered.
// Define SPI_MISO_LAG_EN to add a leading dummy SCK period for slaves that launch SDO on SCK fall.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 8,
  parameter int CS_SETUP   = 8,
  parameter int CS_HOLD    = 8,
  parameter int CS_IDLE    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] txd_data,
  output logic [DATA_WIDTH-1:0] rxd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  spi_cs_n,
  output logic                  spi_sck,
  output logic                  spi_sdo,
  input  logic                  spi_sdi
);

`ifdef SPI_MISO_LAG_EN
  localparam int N = DATA_WIDTH + 1;
`else
  localparam int N = DATA_WIDTH;
`endif

  localparam int T_SETUP = (CS_SETUP < MIN_CS) ? MIN_CS : CS_SETUP;
  localparam int T_HOLD  = (CS_HOLD  < MIN_CS) ? MIN_CS : CS_HOLD;
  localparam int T_IDLE  = (CS_IDLE  < MIN_CS) ? MIN_CS : CS_IDLE;
  localparam int TW      = $clog2(max3(T_SETUP, T_HOLD, T_IDLE) + 1);
  localparam int BW      = $clog2(DATA_WIDTH + 2);

  spi_state_t            state, state_nxt;
  logic [TW-1:0]         tmr;
  logic [BW-1:0]         bit_cnt;
  logic [N-1:0]          tx_load, tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  load, finish, release_busy, last_fall;
  logic                  sck_en, sck_rise, sck_fall;

`ifdef SPI_MISO_LAG_EN
  assign tx_load = {1'b0, txd_data};
`else
  assign tx_load = txd_data;
`endif

  assign sck_en    = (state == ST_SHIFT);
  assign last_fall = sck_fall && (bit_cnt == BW'(N));

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (sck_en),
    .sck  (spi_sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    finish       = 1'b0;
    release_busy = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SETUP;
          load      = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tmr == TW'(T_SETUP - 1)) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_fall) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr == TW'(T_HOLD - 1)) begin
          state_nxt = ST_GAP;
          finish    = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr == TW'(T_IDLE - 1)) begin
          state_nxt    = ST_IDLE;
          release_busy = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Dwell timer shared by SETUP/HOLD/GAP; restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else if ((state_nxt != state) || (state == ST_IDLE)) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_cs_n <= 1'b1;
      spi_sdo  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rxd_data <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
    end else begin
      done <= finish;
      if (load) begin
        spi_cs_n <= 1'b0;
        busy     <= 1'b1;
        spi_sdo  <= tx_load[N-1];
        tx_sr    <= {tx_load[N-2:0], 1'b0};
        bit_cnt  <= '0;
      end
      if (sck_rise) begin
        rx_sr   <= {rx_sr[DATA_WIDTH-2:0], spi_sdi};
        bit_cnt <= bit_cnt + 1'b1;
      end
      // The fall that closes the last period leaves sdo on the final bit.
      if (sck_fall && !last_fall) begin
        spi_sdo <= tx_sr[N-1];
        tx_sr   <= {tx_sr[N-2:0], 1'b0};
      end
      if (finish) begin
        spi_cs_n <= 1'b1;
        rxd_data <= rx_sr;
      end
      if (release_busy) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
